// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between instruction fetch and load/store.
// One access at a time, held for MEM_LAT cycles, round-robin on simultaneous requests.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_owner;
  logic              r_last_winner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_idle;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_resp;

  // Round-robin: on a tie the requester that did not win last time goes first.
  assign w_idle   = (r_state == S_IDLE) && !rst;
  assign w_if_gnt = w_idle && if_req && (!d_req || (r_last_winner == OWN_DATA));
  assign w_d_gnt  = w_idle && d_req && (!if_req || (r_last_winner == OWN_FETCH));
  assign w_resp   = (r_state == S_RESP) && !rst;

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = w_resp && (r_owner == OWN_FETCH);
  assign d_done    = w_resp && (r_owner == OWN_DATA);
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = (r_state == S_ACCESS);
  assign mem_we    = (r_state == S_ACCESS) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_owner       <= OWN_FETCH;
      r_last_winner <= OWN_DATA;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_we          <= 1'b0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_if_gnt || w_d_gnt) begin
            r_owner       <= w_d_gnt;
            r_last_winner <= w_d_gnt;
            r_addr        <= w_d_gnt ? d_addr : if_addr;
            r_we          <= w_d_gnt && d_we;
            if (w_d_gnt) begin
              r_wdata <= d_wdata;
            end
            r_cnt   <= CNT_INIT;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Read data is only valid in the final access cycle.
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              if (r_owner == OWN_FETCH) begin
                r_if_rdata <= mem_rdata;
              end else begin
                r_d_rdata <= mem_rdata;
              end
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT = 2.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic              clock;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int n_checks;
  int n_fail;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    if_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // Reset state; grants forced low while rst is high even with requests up.
    tick();
    tick();
    if_req = 1'b1;
    d_req  = 1'b1;
    settle();
    check("rst_if_gnt", if_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    tick();
    if_req = 1'b0;
    d_req  = 1'b0;
    rst    = 1'b0;

    // Fetch only.
    tick();
    if_req = 1'b1; if_addr = 9'h010; mem_rdata = 32'hA5A50001;
    settle();
    check("f_gnt_c0", if_gnt, 1);
    check("f_dgnt_c0", d_gnt, 0);
    check("f_busy_c0", busy, 0);
    for (int c = 1; c <= 2; c++) begin
      tick();
      if_req = 1'b0;
      if_addr = 9'h1AA;
      settle();
      check($sformatf("f_en_c%0d", c), mem_en, 1);
      check($sformatf("f_we_c%0d", c), mem_we, 0);
      check($sformatf("f_addr_c%0d", c), mem_addr, 9'h010);
      check($sformatf("f_busy_c%0d", c), busy, 1);
      check($sformatf("f_rv_c%0d", c), if_rvalid, 0);
    end
    tick();
    settle();
    check("f_rv_c3", if_rvalid, 1);
    check("f_rdata_c3", if_rdata, 32'hA5A50001);
    check("f_busy_c3", busy, 1);
    check("f_en_c3", mem_en, 0);
    check("f_done_c3", d_done, 0);
    tick();
    settle();
    check("f_busy_c4", busy, 0);
    check("f_rv_c4", if_rvalid, 0);
    check("f_addr_hold_c4", mem_addr, 9'h010);

    // Store; memory returns junk that must not reach d_rdata.
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h1FF; d_wdata = 32'hDEADBEEF;
    mem_rdata = 32'hFFFF0000;
    settle();
    check("s_gnt_c0", d_gnt, 1);
    for (int c = 1; c <= 2; c++) begin
      tick();
      d_req = 1'b0; d_wdata = 32'h0;
      settle();
      check($sformatf("s_en_c%0d", c), mem_en, 1);
      check($sformatf("s_we_c%0d", c), mem_we, 1);
      check($sformatf("s_wdata_c%0d", c), mem_wdata, 32'hDEADBEEF);
      check($sformatf("s_addr_c%0d", c), mem_addr, 9'h1FF);
    end
    tick();
    settle();
    check("s_done_c3", d_done, 1);
    check("s_rv_c3", if_rvalid, 0);
    check("s_we_c3", mem_we, 0);
    tick();
    d_we = 1'b0;
    settle();
    check("s_rdata_c4", d_rdata, 0);
    check("s_done_c4", d_done, 0);

    // Simultaneous requests held: I, D, I, D every 4 cycles.
    do_reset();
    if_req = 1'b1; if_addr = 9'h005; d_req = 1'b1; d_we = 1'b0; d_addr = 9'h006;
    mem_rdata = 32'h0000C0DE;
    settle();
    for (int c = 0; c < 16; c++) begin
      logic slot, fetch_turn;
      if (c > 0) begin
        tick();
        settle();
      end
      slot       = (c % 4) == 0;
      fetch_turn = ((c / 4) % 2) == 0;
      check($sformatf("rr_ig_c%0d", c), if_gnt, slot && fetch_turn);
      check($sformatf("rr_dg_c%0d", c), d_gnt, slot && !fetch_turn);
      check($sformatf("rr_rv_c%0d", c), if_rvalid, ((c % 4) == 3) && fetch_turn);
      check($sformatf("rr_dd_c%0d", c), d_done, ((c % 4) == 3) && !fetch_turn);
    end
    tick();
    if_req = 1'b0; d_req = 1'b0;
    settle();
    check("rr_idle", busy, 0);
    check("rr_if_rdata", if_rdata, 32'h0000C0DE);
    check("rr_d_rdata", d_rdata, 32'h0000C0DE);

    // Load with requester address wandering during the access.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020; mem_rdata = 32'h12345678;
    settle();
    check("l_gnt_c0", d_gnt, 1);
    for (int c = 1; c <= 2; c++) begin
      tick();
      d_req = 1'b0; d_addr = 9'h030;
      settle();
      check($sformatf("l_addr_c%0d", c), mem_addr, 9'h020);
      check($sformatf("l_we_c%0d", c), mem_we, 0);
    end
    tick();
    settle();
    check("l_done_c3", d_done, 1);
    check("l_rdata_c3", d_rdata, 32'h12345678);

    // Reset during the last access cycle of a fetch.
    tick();
    tick();
    if_req = 1'b1; if_addr = 9'h044; mem_rdata = 32'h55AA55AA;
    settle();
    check("a_gnt_c0", if_gnt, 1);
    tick();
    if_req = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    check("a_gnt_c2", if_gnt, 0);
    check("a_rv_c2", if_rvalid, 0);
    tick();
    rst = 1'b0;
    settle();
    check("a_en_c3", mem_en, 0);
    check("a_busy_c3", busy, 0);
    check("a_rv_c3", if_rvalid, 0);
    check("a_if_rdata_c3", if_rdata, 0);
    check("a_d_rdata_c3", d_rdata, 0);
    tick();
    if_req = 1'b1; if_addr = 9'h077; mem_rdata = 32'h0BADF00D;
    settle();
    check("a_rv_c4", if_rvalid, 0);
    check("n_gnt_c0", if_gnt, 1);
    for (int c = 1; c <= 2; c++) begin
      tick();
      if_req = 1'b0;
      settle();
      check($sformatf("n_en_c%0d", c), mem_en, 1);
      check($sformatf("n_addr_c%0d", c), mem_addr, 9'h077);
    end
    tick();
    settle();
    check("n_rv_c3", if_rvalid, 1);
    check("n_rdata_c3", if_rdata, 32'h0BADF00D);
    tick();
    settle();
    check("n_busy_c4", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
